axis_video_out: RTL and testbench

// Converts an AXI4-Stream pixel stream into raster video (rgb/hsync/vsync/den) that drives the HDMI transmitter's rgb/hsync_in/vsync_in/den_in inputs.

---
 rtl/video_timing_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 46 ++++
 rtl/axis_video_out.sv | 207 ++++++++++++++++++++
 tb/tb_axis_video_out.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the AXI4-Stream to raster video path.
// Optional colour-bar pattern generator is enabled by AXIS_VIDEO_PATTERN_EN.
package video_timing_pkg;

  typedef enum logic [1:0] {
    FLUSH      = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } video_state_t;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] tdata;
  } pix_entry_t;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Colour of bar idx, left (0) to right (7).
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = BAR_WHITE;
      3'd1:    bar_colour = BAR_YELLOW;
      3'd2:    bar_colour = BAR_CYAN;
      3'd3:    bar_colour = BAR_GREEN;
      3'd4:    bar_colour = BAR_MAGENTA;
      3'd5:    bar_colour = BAR_RED;
      3'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry.
// Synchronous clear empties the FIFO and takes priority over a same-cycle write.
module sync_fifo #(
  parameter int WIDTH = 26,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array; no reset needed since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_video_out.sv
// AXI4-Stream pixels to raster video (rgb/hsync/vsync/den) for the HDMI transmitter.
// A free-running timing generator never stalls; the stream is locked to it at
// frame boundaries and re-synchronised after underflow or framing errors.
// Define AXIS_VIDEO_PATTERN_EN to add the pattern_en colour-bar input.
module axis_video_out
  import video_timing_pkg::*;
#(
  parameter int          H_ACTIVE      = 640,
  parameter int          H_FP          = 16,
  parameter int          H_SYNC        = 96,
  parameter int          H_BP          = 48,
  parameter int          V_ACTIVE      = 480,
  parameter int          V_FP          = 10,
  parameter int          V_SYNC        = 2,
  parameter int          V_BP          = 33,
  parameter int          SYNC_NEG      = 1,
  parameter int          FIFO_AW       = 10,
  parameter logic [23:0] UNDERFLOW_RGB = 24'h0000FF
) (
  input  logic        clk_pixel,
  input  logic        reset,
`ifdef AXIS_VIDEO_PATTERN_EN
  input  logic        pattern_en,
`endif
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [23:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        den,
  output logic        locked,
  output logic        underflow,
  output logic        frame_err,
  input  logic        status_clear
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_N    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_N    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_INV   = (SYNC_NEG != 0);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, first_pix, last_col, frame_start, hs_on, vs_on;

  video_state_t  state, next_state;
  pix_entry_t    in_entry, head;
  logic          fifo_full, fifo_empty, fifo_wr, fifo_rd, fifo_clr;
  logic          beat_ok, pix_ok, set_uf, set_fe;
  logic          pattern_on;
  logic [23:0]   pattern_rgb;

  // Free-running raster position; vertical advances when horizontal wraps.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + {{(VW-1){1'b0}}, 1'b1};
    end else begin
      h_cnt <= h_cnt + {{(HW-1){1'b0}}, 1'b1};
    end
  end

  assign active      = (h_cnt < H_ACT_N) && (v_cnt < V_ACT_N);
  assign first_pix   = (h_cnt == '0) && (v_cnt == '0);
  assign last_col    = (h_cnt == H_ACT_LAST);
  assign frame_start = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign hs_on       = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_on       = (v_cnt >= VS_START) && (v_cnt < VS_END);

`ifdef AXIS_VIDEO_PATTERN_EN
  logic [2:0] bar_idx;
  assign pattern_on  = pattern_en;
  assign bar_idx     = 3'(({h_cnt, 3'b000}) / (HW+3)'(H_ACTIVE));
  assign pattern_rgb = bar_colour(bar_idx);
`else
  assign pattern_on  = 1'b0;
  assign pattern_rgb = 24'h000000;
`endif

  assign in_entry      = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  assign s_axis_tready = reset ? 1'b0 :
                         (pattern_on || state == FLUSH) ? 1'b1 : !fifo_full;
  assign beat_ok       = s_axis_tvalid && s_axis_tready;
  assign locked        = (state == RUN);

  sync_fifo #(
    .WIDTH ($bits(pix_entry_t)),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk_pixel),
    .reset   (reset),
    .clear   (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (in_entry),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stream lock state register.
  always_ff @(posedge clk_pixel) begin
    if (reset) state <= FLUSH;
    else       state <= next_state;
  end

  // Lock FSM: FIFO write/pop/clear control and error detection.
  always_comb begin
    next_state = state;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    fifo_clr   = 1'b0;
    pix_ok     = 1'b0;
    set_uf     = 1'b0;
    set_fe     = 1'b0;
    if (pattern_on) begin
      next_state = FLUSH;
      fifo_clr   = 1'b1;
    end else begin
      case (state)
        FLUSH: begin
          // Only a start-of-frame beat is kept; everything before it is dropped.
          if (beat_ok && s_axis_tuser) begin
            fifo_wr    = 1'b1;
            next_state = WAIT_FRAME;
          end else begin
            next_state = FLUSH;
          end
        end
        WAIT_FRAME: begin
          fifo_wr = beat_ok;
          if (frame_start && !fifo_empty && head.tuser) next_state = RUN;
          else                                          next_state = WAIT_FRAME;
        end
        RUN: begin
          fifo_wr = beat_ok;
          if (!active) begin
            next_state = RUN;
          end else if (fifo_empty) begin
            set_uf     = 1'b1;
            fifo_clr   = 1'b1;
            next_state = FLUSH;
          end else if ((head.tuser && !first_pix) || (head.tlast != last_col)) begin
            set_fe     = 1'b1;
            fifo_clr   = 1'b1;
            next_state = FLUSH;
          end else begin
            fifo_rd = 1'b1;
            pix_ok  = 1'b1;
          end
        end
        default: next_state = FLUSH;
      endcase
    end
  end

  // Registered video outputs, one cycle behind the raster counters.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb   <= 24'h000000;
      den   <= 1'b0;
      hsync <= SYNC_INV;
      vsync <= SYNC_INV;
    end else begin
      den   <= active;
      hsync <= hs_on ^ SYNC_INV;
      vsync <= vs_on ^ SYNC_INV;
      if (!active)         rgb <= 24'h000000;
      else if (pattern_on) rgb <= pattern_rgb;
      else if (pix_ok)     rgb <= head.tdata;
      else                 rgb <= UNDERFLOW_RGB;
    end
  end

  // Sticky status flags; a set in the same cycle as status_clear wins.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (set_uf)            underflow <= 1'b1;
      else if (status_clear) underflow <= 1'b0;
      else                   underflow <= underflow;
      if (set_fe)            frame_err <= 1'b1;
      else if (status_clear) frame_err <= 1'b0;
      else                   frame_err <= frame_err;
    end
  end

endmodule

// File: tb/tb_axis_video_out.sv
// Scoreboard bench for axis_video_out with small raster timing (16x8 total).
// A per-cycle reference model built from raster arithmetic and a beat queue
// pushes expected outputs; a negedge monitor pops and compares them.
module tb_axis_video_out;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        pattern_en;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic [23:0] rgb;
  logic        hsync, vsync, den, locked, underflow, frame_err;
  logic        status_clear;

  axis_video_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_NEG(1), .FIFO_AW(10), .UNDERFLOW_RGB(24'h0000FF)
  ) dut (
    .clk_pixel     (clk),
    .reset         (reset),
`ifdef AXIS_VIDEO_PATTERN_EN
    .pattern_en    (pattern_en),
`endif
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .rgb           (rgb),
    .hsync         (hsync),
    .vsync         (vsync),
    .den           (den),
    .locked        (locked),
    .underflow     (underflow),
    .frame_err     (frame_err),
    .status_clear  (status_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] rgb;
    logic den, hs, vs, lk, uf, fe;
  } obs_t;

  typedef struct packed {
    logic        u;
    logic        l;
    logic [23:0] d;
  } beat_t;

  obs_t  exp_q[$];
  beat_t mq[$];
  int    checks = 0;
  int    passes = 0;

  // Reference model state: 0 = flushing, 1 = waiting for frame, 2 = running.
  int m_mode = 0;
  int m_n    = 0;
  bit m_uf   = 1'b0;
  bit m_fe   = 1'b0;

  // Inputs as they stand just before the next rising edge.
  bit          smp_ok = 1'b0;
  logic        smp_rst, smp_valid, smp_ready, smp_user, smp_last, smp_clr, smp_pat;
  logic [23:0] smp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  function automatic logic [23:0] bar_of(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Sample inputs mid-cycle for the model.
  always @(negedge clk) begin
    smp_rst   = reset;
    smp_valid = s_axis_tvalid;
    smp_ready = s_axis_tready;
    smp_user  = s_axis_tuser;
    smp_last  = s_axis_tlast;
    smp_data  = s_axis_tdata;
    smp_clr   = status_clear;
    smp_pat   = pattern_en;
    smp_ok    = 1'b1;
  end

  // Reference model: predicts outputs after each rising edge.
  always @(posedge clk) begin
    obs_t        e;
    beat_t       b, hd;
    int          h, v, nxt;
    bit          act, take, clr, ok, su, sf;
    logic [23:0] pix;
    if (smp_ok) begin
      if (smp_rst) begin
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        m_n = 0;
        mq.delete();
        m_mode = 0;
        m_uf = 1'b0;
        m_fe = 1'b0;
      end else begin
        h = m_n % HT;
        v = (m_n / HT) % VT;
        act = (h < HA) && (v < VA);
        take = smp_valid && smp_ready;
        b.u = smp_user; b.l = smp_last; b.d = smp_data;
        clr = 1'b0; ok = 1'b0; su = 1'b0; sf = 1'b0; pix = 24'h0; nxt = m_mode;
        if (smp_pat) begin
          nxt = 0;
          clr = 1'b1;
        end else if (m_mode == 0) begin
          if (take && smp_user) begin
            mq.push_back(b);
            nxt = 1;
          end
        end else if (m_mode == 1) begin
          if (h == HT-1 && v == VT-1 && mq.size() > 0 && mq[0].u) nxt = 2;
          if (take) mq.push_back(b);
        end else begin
          if (act) begin
            if (mq.size() == 0) begin
              su = 1'b1; clr = 1'b1; nxt = 0;
            end else if ((mq[0].u && !(h == 0 && v == 0)) || (mq[0].l != (h == HA-1))) begin
              sf = 1'b1; clr = 1'b1; nxt = 0;
            end else begin
              hd = mq.pop_front();
              pix = hd.d;
              ok = 1'b1;
            end
          end
          if (take && !clr) mq.push_back(b);
        end
        if (clr) mq.delete();
        m_uf = su ? 1'b1 : (smp_clr ? 1'b0 : m_uf);
        m_fe = sf ? 1'b1 : (smp_clr ? 1'b0 : m_fe);
        m_mode = nxt;
        e.rgb = !act ? 24'h0 : (smp_pat ? bar_of(h * 8 / HA) : (ok ? pix : 24'h0000FF));
        e.den = act;
        e.hs  = !(h >= HA+HF && h < HA+HF+HS);
        e.vs  = !(v >= VA+VF && v < VA+VF+VS);
        e.lk  = (m_mode == 2);
        e.uf  = m_uf;
        e.fe  = m_fe;
        m_n++;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs with the oldest expectation.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("video", {5'b0, rgb, den, hsync, vsync}, {5'b0, e.rgb, e.den, e.hs, e.vs});
      check("status", {29'b0, locked, underflow, frame_err}, {29'b0, e.lk, e.uf, e.fe});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [23:0] d, input logic u, input logic l, input int gap);
    bit acc;
    int waitc;
    repeat ($urandom_range(gap)) begin
      s_axis_tvalid = 1'b0;
      tick();
    end
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    acc = 1'b0;
    waitc = 0;
    while (!acc && waitc < 3000) begin
      @(negedge clk);
      acc = s_axis_tready;
      tick();
      waitc++;
    end
    s_axis_tvalid = 1'b0;
    check("beat_accept", {31'b0, acc}, 32'd1);
  endtask

  // err: 0 clean, 1 tuser at (2,5), 2 tlast at (1,6). stall: idle cycles after (1,2).
  task automatic send_frame(input int gap, input int err, input int stall);
    for (int v = 0; v < VA; v++) begin
      for (int h = 0; h < HA; h++) begin
        send_beat({8'(v), 8'(h), 8'hA5},
                  (v == 0 && h == 0) || (err == 1 && v == 2 && h == 5),
                  (h == HA-1) || (err == 2 && v == 1 && h == 6), gap);
        if (stall > 0 && v == 1 && h == 2) repeat (stall) tick();
      end
    end
  endtask

  task automatic wait_pos(input int pos);
    int n = 0;
    while ((m_n % FT) != pos && n < 400) begin
      tick();
      n++;
    end
    check("wait_pos", m_n % FT, pos);
  endtask

  task automatic wait_mode(input int md);
    int n = 0;
    while (m_mode != md && n < 2000) begin
      tick();
      n++;
    end
    check("wait_mode", m_mode, md);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pattern_en = 1'b0; status_clear = 1'b0;
    s_axis_tdata = 24'h0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("tready_in_reset", {31'b0, s_axis_tready}, 32'd0);
    tick();
    reset = 1'b0;

    // Clean frames; lock at the first frame start, then underflow when the stream ends.
    repeat (3) send_frame(1, 0, 0);
    wait_mode(0);

    // Stream stalls after three pixels of line 1, then relocks on fresh frames.
    wait_pos(0);
    send_frame(0, 0, 400);
    send_frame(1, 0, 0);
    send_frame(1, 0, 0);
    wait_mode(0);

    // Misplaced tuser, relock, then clear flags.
    wait_pos(0);
    send_frame(0, 0, 0);
    send_frame(0, 1, 0);
    wait_mode(0);
    send_frame(0, 0, 0);
    send_frame(0, 0, 0);
    wait_mode(2);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    @(negedge clk);
    check("flags_cleared", {30'b0, underflow, frame_err}, 32'd0);
    wait_mode(0);

    // Early tlast.
    wait_pos(0);
    send_frame(0, 0, 0);
    send_frame(0, 2, 0);
    wait_mode(0);

    // Reset mid-frame at v=2,h=4 while locked.
    send_frame(0, 0, 0);
    send_frame(0, 0, 0);
    wait_mode(2);
    wait_pos(2 * HT + 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("after_reset", {rgb, den, hsync, vsync, locked, underflow, frame_err},
          {24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    @(negedge clk);
    check("restart_at_origin", {29'b0, den, hsync, vsync}, {29'b0, 1'b1, 1'b1, 1'b1});
    tick();

`ifdef AXIS_VIDEO_PATTERN_EN
    // Colour bars override the stream.
    pattern_en = 1'b1;
    send_frame(0, 0, 0);
    wait_pos(1);
    check("bar_h0", {8'b0, rgb}, {8'b0, 24'hFFFFFF});
    wait_pos(HA);
    check("bar_h7", {8'b0, rgb}, {8'b0, 24'h000000});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("pattern_ready_unlocked", {30'b0, s_axis_tready, locked}, {30'b0, 1'b1, 1'b0});
      tick();
    end
    pattern_en = 1'b0;
`endif

    repeat (FT) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
